leaf_result_uploader: RTL
=========================

# leaf_result_uploader

Leaf-side transmitter that returns a completed decode to the root hub over the 64-bit parent uplink (`parent_tx_*`). On a start pulse it emits one header word carrying FPGA ID, root count and test ID, then streams the root of every PE, four 16-bit roots per 64-bit word, read through a one-cycle-latency root read port. It sits between the leaf decoder array and the leaf's parent link, mirroring the hub's `up_rx` receiver.

## Interface
- `CODE_DISTANCE`, 5, code distance (informational; sizes `NUM_ROOTS` default)
- `NUM_ROOTS`, 60, number of PE roots per result ((d+1)·(d−1)/2·d)
- `FPGA_ID`, 1, 8-bit source ID placed in header
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request to upload; sampled only in IDLE
- `test_id` in 32: captured on accepted `start`
- `busy` out 1: high from accepted `start` until last word accepted
- `done` out 1: one-cycle pulse after last word handshake
- `root_rd_en` out 1: read strobe
- `root_rd_addr` out $clog2(NUM_ROOTS): PE index
- `root_rd_data` in 16: root of addressed PE, valid the cycle after `root_rd_en`
- `parent_tx_data` out 64: uplink word
- `parent_tx_valid` out 1: word valid
- `parent_tx_ready` in 1: hub accepts word when high with valid

## Operation
- Header word: `{MSG_RESULT[63:56], FPGA_ID[55:48], NUM_ROOTS[47:32], test_id[31:0]}`.
- Payload word k: roots 4k..4k+3, root 4k in bits [15:0], 4k+3 in [63:48]; slots beyond `NUM_ROOTS−1` filled with `PAD_ROOT` (16'hFFFF).
- Payload words = ceil(NUM_ROOTS/4) (15 at default); total message = 1 + that.
- FSM: IDLE → (start) HDR → FETCH → SEND → FETCH … → SEND(last) → IDLE.
  - IDLE: `busy`=0; on `start` latch `test_id`, clear root counter, go HDR.
  - HDR: present header; on handshake go FETCH.
  - FETCH: issue reads for the n = min(4, remaining) roots of the word, one address per cycle ascending; capture each return into slot; after last capture go SEND. Pad slots preloaded with 16'hFFFF.
  - SEND: present word; on handshake either FETCH (roots remain) or IDLE with `done`=1.
- Valid/ready: once `parent_tx_valid` is high, data and valid hold stable until `parent_tx_ready`; valid never deasserts without handshake. Transfer occurs on the rising edge where both are high.
- `start` while `busy`: ignored, no effect on test_id or counters.
- `root_rd_en` only asserted in FETCH; address never exceeds `NUM_ROOTS−1`.
- Reset (any time, including mid-message): all state cleared immediately; message abandoned, no `done`.

## Timing
- Reset values: `parent_tx_valid`=0, `parent_tx_data`=0, `busy`=0, `done`=0, `root_rd_en`=0, `root_rd_addr`=0.
- `start` at edge 0 → header valid from cycle 1; `busy` high from cycle 1.
- Full word with ready held high: FETCH 5 cycles (4 issues + final capture), SEND 1 cycle → one payload word per 6 cycles.
- Default with ready always high: header cycle 1, payload word k valid at cycle 7+6k, last (k=14) at cycle 91; `done` at cycle 92, `busy` low from 92; new `start` accepted at 92.
- Stalls on `parent_tx_ready` add cycles 1:1; no prefetch during SEND.

## Structure
- Shared package `leaf_msg_pkg`: `MSG_RESULT`=8'h03, `PAD_ROOT`=16'hFFFF, `ROOTS_PER_WORD`=4, header field offsets; also consumed by hub receiver.
- Single module; FSM and 2-bit slot counter plus root counter inline, no sub-module.

## Test plan
- Default params, ready high, test_id 32'hCAFE0001, root[i]=i → header 64'h0301_003C_CAFE0001, word0 64'h0003_0002_0001_0000, word14 64'h003B_003A_0039_0038, `done` cycle 92.
- NUM_ROOTS=6 → 2 payload words, word1 64'hFFFF_FFFF_0005_0004; NUM_ROOTS=3 → 1 payload word top slot FFFF.
- Random ready toggling (50%) → data/valid stable during stalls, word sequence identical to ready-high run.
- `start` pulsed during SEND with test_id 32'h1 → ignored; current message completes with original ID.
- Reset asserted while ready low mid-word 7 → valid/busy drop asynchronously, no `done`; next `start` produces a fresh full message from header.
- Read-port check: `root_rd_addr` sequence 0..NUM_ROOTS−1 exactly once per message, `root_rd_en` never in IDLE/HDR/SEND.

Source files
------------

// File: rtl/leaf_msg_pkg.sv
// Message format shared by the leaf uploader and the hub's up_rx receiver.
// Header layout, payload packing constants and the uploader FSM states.
package leaf_msg_pkg;

    localparam logic [7:0]  MSG_RESULT     = 8'h03;
    localparam logic [15:0] PAD_ROOT       = 16'hFFFF;
    localparam int          ROOTS_PER_WORD = 4;
    localparam int          ROOT_W         = 16;

    // Header field LSB positions within the 64-bit word
    localparam int HDR_TYPE_LSB = 56;
    localparam int HDR_SRC_LSB  = 48;
    localparam int HDR_CNT_LSB  = 32;
    localparam int HDR_TID_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND
    } upl_state_t;

    function automatic logic [63:0] make_header(input logic [7:0] src,
                                                input logic [15:0] cnt,
                                                input logic [31:0] tid);
        logic [63:0] h;
        h = '0;
        h[HDR_TYPE_LSB +: 8]  = MSG_RESULT;
        h[HDR_SRC_LSB  +: 8]  = src;
        h[HDR_CNT_LSB  +: 16] = cnt;
        h[HDR_TID_LSB  +: 32] = tid;
        return h;
    endfunction

endpackage

// File: rtl/leaf_result_uploader_if.sv
// 64-bit valid/ready uplink from a leaf to its parent hub.
interface leaf_result_uploader_if;

    logic [63:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/leaf_result_uploader.sv
// Streams a decode result (header + packed PE roots) to the parent hub.
// Roots are pulled through a 1-cycle-latency read port, four per uplink word.
module leaf_result_uploader
    import leaf_msg_pkg::*;
#(
    parameter int CODE_DISTANCE = 5,
    parameter int NUM_ROOTS     = (CODE_DISTANCE + 1) * (CODE_DISTANCE - 1) / 2 * CODE_DISTANCE,
    parameter int FPGA_ID       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [31:0]                  test_id,
    output logic                         busy,
    output logic                         done,
    output logic                         root_rd_en,
    output logic [$clog2(NUM_ROOTS)-1:0] root_rd_addr,
    input  logic [15:0]                  root_rd_data,
    leaf_result_uploader_if.master       parent_tx
);

    localparam int AW = $clog2(NUM_ROOTS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ROOTS - 1);
    localparam logic [63:0]   PAD_WORD  = {ROOTS_PER_WORD{PAD_ROOT}};

    upl_state_t state;
    logic [1:0] slot;
    logic [1:0] cap_slot;
    logic       cap_vld;
    logic       cap_last;
    logic       last_issue;

    // A word's reads end at slot 3 or at the final root, whichever comes first
    assign last_issue = (slot == 2'd3) || (root_rd_addr == LAST_ADDR);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            parent_tx.data  <= '0;
            parent_tx.valid <= 1'b0;
            done            <= 1'b0;
            root_rd_en      <= 1'b0;
            root_rd_addr    <= '0;
            slot            <= '0;
            cap_slot        <= '0;
            cap_vld         <= 1'b0;
            cap_last        <= 1'b0;
        end else begin
            done     <= 1'b0;
            cap_vld  <= root_rd_en;
            cap_slot <= slot;
            cap_last <= root_rd_en && last_issue;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        parent_tx.data  <= make_header(8'(FPGA_ID), 16'(NUM_ROOTS), test_id);
                        parent_tx.valid <= 1'b1;
                        root_rd_addr    <= '0;
                        state           <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (parent_tx.ready) begin
                        parent_tx.valid <= 1'b0;
                        parent_tx.data  <= PAD_WORD;
                        root_rd_en      <= 1'b1;
                        slot            <= '0;
                        state           <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (root_rd_en) begin
                        if (last_issue) begin
                            root_rd_en <= 1'b0;
                        end else begin
                            root_rd_addr <= root_rd_addr + 1'b1;
                            slot         <= slot + 1'b1;
                        end
                    end
                    // Data bus is free while valid is low, so it doubles as the slot buffer
                    if (cap_vld) begin
                        parent_tx.data[ROOT_W*cap_slot +: ROOT_W] <= root_rd_data;
                        if (cap_last) begin
                            parent_tx.valid <= 1'b1;
                            state           <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (parent_tx.ready) begin
                        parent_tx.valid <= 1'b0;
                        if (root_rd_addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            parent_tx.data <= PAD_WORD;
                            root_rd_en     <= 1'b1;
                            root_rd_addr   <= root_rd_addr + 1'b1;
                            slot           <= '0;
                            state          <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
